// File: rtl/lcd_time_writer.sv
// Writes the "MM:SS" time onto line 1 of an HD44780-style 16x2 LCD over its 8-bit write-only bus.
// Runs the controller init sequence after power-up, then rewrites columns 0-4 whenever the time changes.
module lcd_time_writer #(
    parameter int E_PULSE_CYCLES      = 16,
    parameter int CMD_WAIT_CYCLES     = 2500,
    parameter int CLEAR_WAIT_CYCLES   = 100000,
    parameter int POWERUP_WAIT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char1,
    input  logic [7:0] char2,
    input  logic [7:0] char3,
    input  logic [7:0] char4,
    input  logic [7:0] char5,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       busy
);

    localparam int MAX_A = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_B = (E_PULSE_CYCLES > POWERUP_WAIT_CYCLES) ? E_PULSE_CYCLES : POWERUP_WAIT_CYCLES;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    state_t        state;
    phase_t        phase;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    idx;
    logic          first_frame;
    logic [39:0]   shadow;
    logic [39:0]   frame_in;

    assign frame_in = {char1, char2, char3, char4, char5};
    assign lcd_rw   = 1'b0;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] shadow_byte(input logic [39:0] s, input logic [2:0] i);
        case (i)
            3'd0:    return s[39:32];
            3'd1:    return s[31:24];
            3'd2:    return s[23:16];
            3'd3:    return s[15:8];
            default: return s[7:0];
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_POWERUP;
            phase       <= PH_SETUP;
            wait_cnt    <= '0;
            idx         <= '0;
            first_frame <= 1'b1;
            shadow      <= '0;
            lcd_data    <= 8'h00;
            lcd_rs      <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_on      <= 1'b0;
            busy        <= 1'b1;
        end else begin
            lcd_on <= 1'b1;
            case (state)
                ST_POWERUP: begin
                    if (wait_cnt == PWR_LAST) begin
                        state    <= ST_INIT;
                        phase    <= PH_SETUP;
                        idx      <= '0;
                        wait_cnt <= '0;
                        lcd_data <= init_cmd(3'd0);
                        lcd_rs   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    // Inputs are sampled only here, so a frame is never torn by a mid-frame change.
                    if (frame_in != shadow || first_frame) begin
                        shadow      <= frame_in;
                        first_frame <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_ADDR;
                        phase       <= PH_SETUP;
                        lcd_data    <= 8'h80;
                        lcd_rs      <= 1'b0;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            lcd_en   <= 1'b1;
                            phase    <= PH_PULSE;
                            wait_cnt <= PULSE_LOAD;
                        end
                        PH_PULSE: begin
                            if (wait_cnt == '0) begin
                                lcd_en   <= 1'b0;
                                phase    <= PH_HOLD;
                                // Clear-display needs the long settle time; everything else is short.
                                wait_cnt <= (!lcd_rs && lcd_data == 8'h01) ? CLEAR_LOAD : CMD_LOAD;
                            end else begin
                                wait_cnt <= wait_cnt - CW'(1);
                            end
                        end
                        PH_HOLD: begin
                            if (wait_cnt != '0) begin
                                wait_cnt <= wait_cnt - CW'(1);
                            end else begin
                                phase <= PH_SETUP;
                                case (state)
                                    ST_INIT: begin
                                        if (idx == 3'd3) begin
                                            state <= ST_IDLE;
                                            busy  <= 1'b0;
                                        end else begin
                                            idx      <= idx + 3'd1;
                                            lcd_data <= init_cmd(idx + 3'd1);
                                        end
                                    end
                                    ST_ADDR: begin
                                        state    <= ST_DATA;
                                        idx      <= '0;
                                        lcd_rs   <= 1'b1;
                                        lcd_data <= shadow_byte(shadow, 3'd0);
                                    end
                                    default: begin
                                        if (idx == 3'd4) begin
                                            state <= ST_IDLE;
                                            busy  <= 1'b0;
                                        end else begin
                                            idx      <= idx + 3'd1;
                                            lcd_data <= shadow_byte(shadow, idx + 3'd1);
                                        end
                                    end
                                endcase
                            end
                        end
                        default: phase <= PH_SETUP;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_time_writer.sv
// Bench for lcd_time_writer: a bus monitor checks strobe timing and matches every written byte
// against a queue of bytes predicted from the displayed-time model.
module tb_lcd_time_writer;
    localparam int E   = 2;
    localparam int CMD = 4;
    localparam int CLR = 10;
    localparam int PWR = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char1, char2, char3, char4, char5;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy;

    always #5 clk = ~clk;

    lcd_time_writer #(
        .E_PULSE_CYCLES(E),
        .CMD_WAIT_CYCLES(CMD),
        .CLEAR_WAIT_CYCLES(CLR),
        .POWERUP_WAIT_CYCLES(PWR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .char1(char1),
        .char2(char2),
        .char3(char3),
        .char4(char4),
        .char5(char5),
        .lcd_data(lcd_data),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_en(lcd_en),
        .lcd_on(lcd_on),
        .busy(busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  exp_q[$];
    int          strobe_cnt = 0;
    int          pe_cnt = 0;
    logic [39:0] shown;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input logic [8:0] b);
        return (b == 9'h001) ? CLR : CMD;
    endfunction

    function automatic logic [39:0] mmss(input int m, input int s);
        logic [7:0] a, b, c, d;
        a = 8'h30 + 8'(m / 10);
        b = 8'h30 + 8'(m % 10);
        c = 8'h30 + 8'(s / 10);
        d = 8'h30 + 8'(s % 10);
        return {a, b, 8'h3A, c, d};
    endfunction

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic push_frame(input logic [39:0] v);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, v[39-8*i -: 8]});
    endtask

    task automatic set_time(input logic [39:0] v);
        @(posedge clk);
        #1;
        {char1, char2, char3, char4, char5} = v;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int budget = 0;
        while (quiet < 3 && budget < 3000) begin
            @(negedge clk);
            #1;
            budget++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        check(tag, quiet >= 3, 1);
    endtask

    task automatic wait_strobes(input int n);
        int target = strobe_cnt + n;
        int budget = 0;
        while (strobe_cnt < target && budget < 3000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check("strobe_wait", strobe_cnt >= target, 1);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) pe_cnt <= 0;
        else pe_cnt <= pe_cnt + 1;
    end

    // Bus monitor and scoreboard.
    logic       prev_en = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_rs = 1'b0;
    logic       first_byte = 1'b1;
    logic [8:0] last_byte = 9'h000;
    int         hi_len = 0;
    int         hold_left = 0;
    int         last_rise = 0;

    always @(negedge clk) begin
        if (rst) begin
            first_byte = 1'b1;
            hi_len = 0;
            hold_left = 0;
        end else if (lcd_en && !prev_en) begin
            strobe_cnt++;
            check("setup_data", lcd_data, prev_data);
            check("setup_rs", lcd_rs, prev_rs);
            check("rw_low", lcd_rw, 0);
            check("busy_in_frame", busy, 1);
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte", {lcd_rs, lcd_data}, exp_q.pop_front());
            if (first_byte)
                check("powerup_quiet", pe_cnt >= PWR + 1 && pe_cnt <= PWR + 2, 1);
            else if ({lcd_rs, lcd_data} == 9'h080)
                check("addr_gap", (pe_cnt - last_rise) >= 2 + E + wait_of(last_byte), 1);
            else
                check("byte_interval", pe_cnt - last_rise, 1 + E + wait_of(last_byte));
            first_byte = 1'b0;
            last_rise = pe_cnt;
            last_byte = {lcd_rs, lcd_data};
            hi_len = 1;
        end else if (lcd_en) begin
            hi_len++;
            check("pulse_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
        end else if (prev_en) begin
            check("pulse_width", hi_len, E);
            check("fall_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
            hold_left = wait_of(last_byte) - 1;
        end else if (hold_left > 0) begin
            check("hold_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
            hold_left--;
        end
        prev_en = lcd_en;
        prev_data = lcd_data;
        prev_rs = lcd_rs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, m, s, k;
        logic [39:0] v1, v2;

        {char1, char2, char3, char4, char5} = mmss(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", lcd_data, 8'h00);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_en", lcd_en, 0);
        check("rst_on", lcd_on, 0);
        check("rst_busy", busy, 1);

        // Init sequence plus the forced first frame.
        push_init();
        push_frame(mmss(0, 0));
        shown = mmss(0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("init_idle");
        check("sb_drain_init", exp_q.size(), 0);
        check("lcd_on_run", lcd_on, 1);

        // Change detection, then a static window with no bus activity.
        set_time(mmss(0, 5));
        push_frame(mmss(0, 5));
        shown = mmss(0, 5);
        wait_idle("chg_idle");
        check("sb_drain_chg", exp_q.size(), 0);
        s0 = strobe_cnt;
        repeat (200) @(negedge clk);
        check("static_no_strobe", strobe_cnt - s0, 0);

        // Change to 00:07 during the third data byte of the 00:06 frame.
        s0 = strobe_cnt;
        set_time(mmss(0, 6));
        push_frame(mmss(0, 6));
        wait_strobes(4);
        set_time(mmss(0, 7));
        push_frame(mmss(0, 7));
        shown = mmss(0, 7);
        wait_idle("mid_idle");
        check("sb_drain_mid", exp_q.size(), 0);
        check("mid_two_frames", strobe_cnt - s0, 12);

        // Randomized changes, either while idle or part-way through a frame.
        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            v1 = mmss(m, s);
            if ($urandom_range(0, 1) == 1) begin
                set_time(v1);
                if (v1 != shown) push_frame(v1);
                shown = v1;
            end else begin
                if (v1 == shown) v1 = mmss(m, (s + 1) % 60);
                set_time(v1);
                push_frame(v1);
                k = $urandom_range(1, 6);
                wait_strobes(k);
                v2 = ($urandom_range(0, 1) == 1) ? v1 : mmss($urandom_range(0, 59), $urandom_range(0, 59));
                set_time(v2);
                if (v2 != v1) push_frame(v2);
                shown = v2;
            end
            wait_idle("rand_idle");
            check("sb_drain_rand", exp_q.size(), 0);
        end

        // Reset in the middle of an enable pulse.
        v1 = (shown == mmss(12, 34)) ? mmss(43, 21) : mmss(12, 34);
        set_time(v1);
        push_frame(v1);
        wait_strobes(2);
        check("en_high_pre_rst", lcd_en, 1);
        rst = 1'b1;
        #1;
        check("abort_en", lcd_en, 0);
        check("abort_on", lcd_on, 0);
        check("abort_busy", busy, 1);
        check("abort_data", lcd_data, 8'h00);
        exp_q.delete();
        push_init();
        push_frame(v1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("reinit_idle");
        check("sb_drain_reinit", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
